// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared CPU bus types, owner codes and default widths
package cpu_bus_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_FAIR_LIMIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    // Counter must be able to hold FAIR_LIMIT itself, so size for limit+1 values
    function automatic int fair_cnt_w(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - SRAM-like request/response port bundle
interface sram_port_arbiter_if
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req;
    logic              wr;
    logic [3:0]        wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    // Requester side: issues requests, receives acknowledges and read data
    modport master (
        output req, wr, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    // Responder side: accepts requests, returns acknowledges and read data
    modport slave (
        input  req, wr, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/arb_prio2_fair.sv
// rtl/arb_prio2_fair.sv - data-priority winner select with fetch fairness counter
module arb_prio2_fair
    import cpu_bus_pkg::*;
#(
    parameter int FAIR_LIMIT = DEF_FAIR_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic idle,
    input  logic inst_req,
    input  logic data_req,
    output logic win_data
);
    localparam int CNT_W = fair_cnt_w(FAIR_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FAIR_LIMIT);

    logic [CNT_W-1:0] fair_cnt;

    // Data wins unless fetch has been passed over FAIR_LIMIT times in a row
    assign win_data = data_req && !(inst_req && (fair_cnt == LIMIT));

    // Count data grants taken while fetch waits; any fetch grant or idle fetch clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            fair_cnt <= '0;
        end else if (idle) begin
            if (!inst_req || !win_data) begin
                fair_cnt <= '0;
            end else if (fair_cnt != LIMIT) begin
                fair_cnt <= fair_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one memory port between fetch and load/store
module sram_port_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FAIR_LIMIT = DEF_FAIR_LIMIT
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_port_arbiter_if.slave   inst,
    sram_port_arbiter_if.slave   data,
    sram_port_arbiter_if.master  m,
    output logic                 busy,
    output logic                 owner
);
    arb_state_t        state;
    logic              idle;
    logic              any_req;
    logic              win_data;
    logic              sel_data;
    logic              fwd;
    logic              sel_wr;
    logic [3:0]        sel_wstrb;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign idle    = (state == ST_IDLE);
    assign any_req = inst.req | data.req;

    arb_prio2_fair #(.FAIR_LIMIT(FAIR_LIMIT)) u_arb (
        .clk      (clk),
        .reset    (reset),
        .idle     (idle),
        .inst_req (inst.req),
        .data_req (data.req),
        .win_data (win_data)
    );

    // In IDLE the live winner drives the port; afterwards the latched owner does
    assign sel_data  = idle ? win_data : owner;
    assign fwd       = !reset && ((idle && any_req) || (state == ST_ADDR));
    assign sel_wr    = sel_data ? data.wr    : inst.wr;
    assign sel_wstrb = sel_data ? data.wstrb : inst.wstrb;
    assign sel_addr  = sel_data ? data.addr  : inst.addr;
    assign sel_wdata = sel_data ? data.wdata : inst.wdata;

    assign m.req   = fwd;
    assign m.wr    = fwd & sel_wr;
    assign m.wstrb = fwd ? sel_wstrb : 4'h0;
    assign m.addr  = fwd ? sel_addr  : '0;
    assign m.wdata = fwd ? sel_wdata : '0;

    // addr_ok only while a request is forwarded; data_ok only in DATA, so they never overlap
    assign inst.addr_ok = fwd && m.addr_ok && (sel_data == OWN_INST);
    assign data.addr_ok = fwd && m.addr_ok && (sel_data == OWN_DATA);
    assign inst.data_ok = !reset && (state == ST_DATA) && m.data_ok && (owner == OWN_INST);
    assign data.data_ok = !reset && (state == ST_DATA) && m.data_ok && (owner == OWN_DATA);
    assign inst.rdata   = m.rdata;
    assign data.rdata   = m.rdata;

    // Transaction FSM: grant in IDLE, wait for addr_ok in ADDR, wait for data_ok in DATA
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            owner <= OWN_INST;
            busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner <= win_data ? OWN_DATA : OWN_INST;
                        state <= m.addr_ok ? ST_DATA : ST_ADDR;
                        busy  <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (m.addr_ok) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (m.data_ok) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed and randomized bench for sram_port_arbiter
module tb_sram_port_arbiter;
    import cpu_bus_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int FL = 4;

    typedef struct packed {
        logic          mreq;
        logic          mwr;
        logic [3:0]    mstrb;
        logic [AW-1:0] maddr;
        logic [DW-1:0] mwdata;
        logic          iaok;
        logic          idok;
        logic          daok;
        logic          ddok;
        logic          busy;
        logic          own;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic busy, owner;

    logic          i_req, i_wr, d_req, d_wr;
    logic [3:0]    i_wstrb, d_wstrb;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] i_wdata, d_wdata, mrdata;
    logic          ma_ok, md_ok;
    bit            keep_req;

    int   checks = 0;
    int   failures = 0;
    vec_t obs;
    logic [DW-1:0] obs_irdata, obs_drdata;

    bit mdl_out, mdl_acc, mdl_own;
    int mdl_streak;
    bit seen[$];
    bit exp_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    always #5 clk = ~clk;

    sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) inst_if ();
    sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) data_if ();
    sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m_if ();

    assign inst_if.req   = i_req;
    assign inst_if.wr    = i_wr;
    assign inst_if.wstrb = i_wstrb;
    assign inst_if.addr  = i_addr;
    assign inst_if.wdata = i_wdata;
    assign data_if.req   = d_req;
    assign data_if.wr    = d_wr;
    assign data_if.wstrb = d_wstrb;
    assign data_if.addr  = d_addr;
    assign data_if.wdata = d_wdata;
    assign m_if.addr_ok  = ma_ok;
    assign m_if.data_ok  = md_ok;
    assign m_if.rdata    = mrdata;

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FAIR_LIMIT(FL)) dut (
        .clk   (clk),
        .reset (reset),
        .inst  (inst_if),
        .data  (data_if),
        .m     (m_if),
        .busy  (busy),
        .owner (owner)
    );

    task automatic check(input string tag, input logic [127:0] o, input logic [127:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic vec_t payload(input bit sel);
        vec_t v = '0;
        v.mreq   = 1'b1;
        v.mwr    = sel ? d_wr    : i_wr;
        v.mstrb  = sel ? d_wstrb : i_wstrb;
        v.maddr  = sel ? d_addr  : i_addr;
        v.mwdata = sel ? d_wdata : i_wdata;
        return v;
    endfunction

    // One clock: predict from the transaction-level model, compare, advance model, run requesters
    task automatic cycle();
        vec_t exp;
        bit   w;
        @(negedge clk);
        exp = '0;
        w   = 1'b0;
        if (!reset) begin
            if (!mdl_out) begin
                if (i_req || d_req) begin
                    w   = d_req && !(i_req && mdl_streak >= FL);
                    exp = payload(w);
                    if (ma_ok) begin
                        if (w) exp.daok = 1'b1; else exp.iaok = 1'b1;
                    end
                end
            end else if (!mdl_acc) begin
                exp = payload(mdl_own);
                if (ma_ok) begin
                    if (mdl_own) exp.daok = 1'b1; else exp.iaok = 1'b1;
                end
            end else if (md_ok) begin
                if (mdl_own) exp.ddok = 1'b1; else exp.idok = 1'b1;
            end
        end
        exp.busy = mdl_out;
        exp.own  = mdl_own;
        obs = {m_if.req, m_if.wr, m_if.wstrb, m_if.addr, m_if.wdata,
               inst_if.addr_ok, inst_if.data_ok, data_if.addr_ok, data_if.data_ok, busy, owner};
        obs_irdata = inst_if.rdata;
        obs_drdata = data_if.rdata;
        check("cycle", 128'(obs), 128'(exp));
        if (exp.idok || exp.ddok) begin
            check("rdata_inst", 128'(obs_irdata), 128'(mrdata));
            check("rdata_data", 128'(obs_drdata), 128'(mrdata));
        end
        if (reset) begin
            mdl_out = 0; mdl_acc = 0; mdl_own = 0; mdl_streak = 0;
        end else if (!mdl_out) begin
            if (!i_req) mdl_streak = 0;
            if (i_req || d_req) begin
                if (i_req) mdl_streak = w ? ((mdl_streak < FL) ? mdl_streak + 1 : FL) : 0;
                mdl_own = w;
                mdl_out = 1;
                mdl_acc = ma_ok;
            end
        end else if (!mdl_acc) begin
            mdl_acc = ma_ok;
        end else if (md_ok) begin
            mdl_out = 0;
            mdl_acc = 0;
        end
        @(posedge clk);
        #1;
        if (obs.iaok) begin
            if (keep_req) i_addr = i_addr + 4; else i_req = 1'b0;
        end
        if (obs.daok) begin
            if (keep_req) d_addr = d_addr + 4; else d_req = 1'b0;
        end
    endtask

    task automatic drain();
        ma_ok = 1'b1;
        md_ok = 1'b1;
        keep_req = 0;
        for (int k = 0; k < 40 && (mdl_out || i_req || d_req); k++) cycle();
        i_req = 1'b0;
        d_req = 1'b0;
        cycle();
        check("drain_idle", 128'(obs.busy), 128'(1'b0));
    endtask

    initial begin
        reset = 1'b1; keep_req = 0;
        i_req = 1'b1; i_wr = 1'b0; i_wstrb = 4'h0; i_addr = 32'h1c00_0000; i_wdata = '0;
        d_req = 1'b1; d_wr = 1'b0; d_wstrb = 4'h0; d_addr = 32'h1c00_0100; d_wdata = '0;
        ma_ok = 1'b0; md_ok = 1'b0; mrdata = '0;
        mdl_out = 0; mdl_acc = 0; mdl_own = 0; mdl_streak = 0;

        // Reset held with both requests pending
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("t1_reset_quiet", 128'({obs.mreq, obs.iaok, obs.idok, obs.daok, obs.ddok, obs.busy}), 128'(6'b0));
        end
        reset = 1'b0;
        cycle();
        check("t1_data_first", 128'({obs.mreq, obs.maddr}), 128'({1'b1, 32'h1c00_0100}));
        ma_ok = 1'b1;
        cycle();
        check("t1_data_aok", 128'({obs.iaok, obs.daok, obs.own}), 128'(3'b011));
        drain();

        // Fetch alone against zero-wait memory
        i_req = 1'b1; i_addr = 32'h1c00_0000; mrdata = 32'h0280_0401;
        cycle();
        check("t2_aok_c0", 128'({obs.iaok, obs.idok}), 128'(2'b10));
        cycle();
        check("t2_dok_c1", 128'({obs.iaok, obs.idok}), 128'(2'b01));
        check("t2_rdata", 128'(obs_irdata), 128'(32'h0280_0401));
        cycle();
        check("t2_idle_c2", 128'({obs.busy, obs.iaok, obs.idok, obs.daok, obs.ddok}), 128'(5'b0));

        // Data store with delayed addr_ok while fetch waits
        i_req = 1'b1; i_addr = 32'h1c00_0040;
        d_req = 1'b1; d_wr = 1'b1; d_wstrb = 4'hf; d_addr = 32'h1c00_1000; d_wdata = 32'hcafe_f00d;
        ma_ok = 1'b0; md_ok = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("t3_hold", 128'({obs.mreq, obs.mwr, obs.mstrb, obs.maddr, obs.mwdata}),
                  128'({1'b1, 1'b1, 4'hf, 32'h1c00_1000, 32'hcafe_f00d}));
            check("t3_no_ok", 128'({obs.iaok, obs.daok}), 128'(2'b00));
        end
        ma_ok = 1'b1;
        cycle();
        check("t3_aok_c3", 128'({obs.iaok, obs.daok}), 128'(2'b01));
        d_wr = 1'b0; d_wstrb = 4'h0;
        drain();

        // Both requesters saturated: fairness every FAIR_LIMIT data grants
        keep_req = 1; i_req = 1'b1; d_req = 1'b1; ma_ok = 1'b1; md_ok = 1'b1;
        seen.delete();
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (obs.iaok) seen.push_back(1'b0);
            if (obs.daok) seen.push_back(1'b1);
        end
        check("t4_grant_count", 128'(seen.size()), 128'(10));
        for (int k = 0; k < 10 && k < seen.size(); k++)
            check($sformatf("t4_grant_%0d", k), 128'(seen[k]), 128'(exp_order[k]));
        drain();

        // Spurious responses
        ma_ok = 1'b0; md_ok = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cycle();
            check("t5_idle_spur", 128'({obs.busy, obs.iaok, obs.idok, obs.daok, obs.ddok}), 128'(5'b0));
        end
        d_req = 1'b1; d_addr = 32'h1c00_2000; ma_ok = 1'b1; md_ok = 1'b0;
        cycle();
        for (int k = 0; k < 2; k++) begin
            cycle();
            check("t5_data_spur", 128'({obs.busy, obs.iaok, obs.idok, obs.daok, obs.ddok}), 128'(5'b10000));
        end
        ma_ok = 1'b0; md_ok = 1'b1;
        cycle();
        check("t5_dok", 128'(obs.ddok), 128'(1'b1));
        drain();

        // Reset while waiting for data
        d_req = 1'b1; d_addr = 32'h1c00_3000; ma_ok = 1'b1; md_ok = 1'b0;
        cycle();
        ma_ok = 1'b0;
        cycle();
        check("t6_in_data", 128'(obs.busy), 128'(1'b1));
        reset = 1'b1; md_ok = 1'b1;
        cycle();
        check("t6_rst_quiet", 128'({obs.mreq, obs.idok, obs.ddok}), 128'(3'b0));
        reset = 1'b0;
        cycle();
        check("t6_dropped", 128'({obs.busy, obs.idok, obs.ddok}), 128'(3'b0));

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            ma_ok  = ($urandom_range(0, 2) != 0);
            md_ok  = $urandom_range(0, 1) != 0;
            mrdata = $urandom;
            reset  = ($urandom_range(0, 99) == 0);
            if (!i_req && $urandom_range(0, 1) != 0) begin
                i_req = 1'b1; i_wr = 1'b0; i_wstrb = 4'h0; i_addr = $urandom; i_wdata = $urandom;
            end
            if (!d_req && $urandom_range(0, 1) != 0) begin
                d_req = 1'b1; d_wr = $urandom_range(0, 1) != 0; d_wstrb = 4'($urandom);
                d_addr = $urandom; d_wdata = $urandom;
            end
            cycle();
        end
        reset = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
